// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter stage feeding the external adder with
// {pc, INSTR_BYTES} and registering add_sum as the next sequential PC on an
// accepted fetch. Branch redirects and halt requests arrive from downstream.
// Optional build macro: PC_ALIGN_CHECK_EN (rejects redirect targets that are
// not a multiple of INSTR_BYTES and raises a sticky misalign_err).
module pc_sequencer #(
    parameter int unsigned      WIDTH       = 63,
    parameter logic [WIDTH:0]   RESET_PC    = '0,
    parameter int unsigned      INSTR_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH:0]   add_a,
    output logic [WIDTH:0]   add_b,
    input  logic [WIDTH:0]   add_sum,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    output logic [WIDTH:0]   fetch_pc,
    input  logic             redirect_valid,
    input  logic [WIDTH:0]   redirect_target,
    input  logic             halt_req,
    output logic             halted,
    output logic             misalign_err
);

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [WIDTH:0] INC = (WIDTH+1)'(INSTR_BYTES);

    logic [1:0]     state;
    logic [1:0]     state_nxt;
    logic           boot_armed;
    logic [WIDTH:0] pc;
    logic [WIDTH:0] pc_nxt;
    logic           accept;
    logic           redirect_take;

    assign add_a       = pc;
    assign add_b       = INC;
    assign fetch_pc    = pc;
    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALTED);
    assign accept      = fetch_valid & fetch_ready;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH:0] ALIGN_MASK = INC - (WIDTH+1)'(1);

    logic misaligned;
    logic err_q;

    assign misaligned    = (redirect_target & ALIGN_MASK) != '0;
    assign redirect_take = redirect_valid & ~misaligned;
    assign misalign_err  = err_q;

    // Sticky alignment error: set by any rejected redirect, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (redirect_valid && misaligned) begin
            err_q <= 1'b1;
        end
    end
`else
    assign redirect_take = redirect_valid;
    assign misalign_err  = 1'b0;
`endif

    // Next-PC selection: redirect beats accept beats hold, in every state
    always_comb begin
        pc_nxt = pc;
        if (redirect_take) begin
            pc_nxt = redirect_target;
        end else if (accept) begin
            pc_nxt = add_sum;
        end
    end

    // Sequencer state transitions; BOOT spends one full cycle after its first edge
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT: begin
                if (boot_armed) begin
                    state_nxt = halt_req ? HALTED : RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (!halt_req) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    // PC, state and boot-delay registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            state      <= BOOT;
            boot_armed <= 1'b0;
        end else begin
            pc         <= pc_nxt;
            state      <= state_nxt;
            boot_armed <= (state == BOOT);
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vectors, accepted fetch PCs checked by
// a scoreboard queue that a negedge monitor drains. Models the external adder.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] add_a;
    logic [63:0] add_b;
    logic [63:0] add_sum;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [63:0] fetch_pc;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        halt_req;
    logic        halted;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    assign add_sum = add_a + add_b;

    pc_sequencer #(
        .WIDTH       (63),
        .RESET_PC    (64'h1000),
        .INSTR_BYTES (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .add_a           (add_a),
        .add_b           (add_b),
        .add_sum         (add_sum),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_pc        (fetch_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .halted          (halted),
        .misalign_err    (misalign_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle, record the PC expected to be accepted, then
    // return just after the next rising edge.
    task automatic cyc(input logic r, input logic h, input logic rv, input logic [63:0] tgt,
                       input bit acc, input logic [63:0] ep);
        fetch_ready     = r;
        halt_req        = h;
        redirect_valid  = rv;
        redirect_target = tgt;
        if (acc) exp_q.push_back(ep);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted fetch must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && fetch_valid && fetch_ready) begin
            if (exp_q.size() == 0) begin
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL accept_unexpected got=%h required=none", fetch_pc);
            end else begin
                check("accept_pc", fetch_pc, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        fetch_ready    = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        rst_n = 1'b0;
        #1;
        check("rst_fetch_pc", fetch_pc, 64'h1000);
        check("rst_add_a", add_a, 64'h1000);
        check("rst_add_b", add_b, 64'd4);
        check("rst_valid", {63'd0, fetch_valid}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_misalign", {63'd0, misalign_err}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        check("boot_valid_e1", {63'd0, fetch_valid}, 64'd0);
        cyc(1, 0, 0, 0, 0, 0);
        check("boot_valid_e2", {63'd0, fetch_valid}, 64'd1);
        check("boot_pc", fetch_pc, 64'h1000);
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_ready = 1'b0;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Sequential fetches
        cyc(1, 0, 0, 0, 1, 64'h1000);
        check("seq_1004", fetch_pc, 64'h1004);
        cyc(1, 0, 0, 0, 1, 64'h1004);
        check("seq_1008", fetch_pc, 64'h1008);

        // Stall three cycles at 0x1008
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            check("stall_pc", fetch_pc, 64'h1008);
            check("stall_valid", {63'd0, fetch_valid}, 64'd1);
        end
        cyc(1, 0, 0, 0, 1, 64'h1008);
        check("resume_100c", fetch_pc, 64'h100C);
        cyc(1, 0, 0, 0, 1, 64'h100C);
        check("seq_1010", fetch_pc, 64'h1010);

        // Halt for four cycles, accept in the first, redirect while halted
        cyc(1, 1, 0, 0, 1, 64'h1010);
        check("halt_halted", {63'd0, halted}, 64'd1);
        check("halt_valid", {63'd0, fetch_valid}, 64'd0);
        check("halt_pc", fetch_pc, 64'h1014);
        cyc(1, 1, 0, 0, 0, 0);
        check("halt_hold_pc", fetch_pc, 64'h1014);
        cyc(1, 1, 1, 64'h3000, 0, 0);
        check("halt_redir_pc", fetch_pc, 64'h3000);
        check("halt_redir_halted", {63'd0, halted}, 64'd1);
        cyc(1, 1, 0, 0, 0, 0);
        check("halt_hold2_pc", fetch_pc, 64'h3000);
        cyc(1, 0, 0, 0, 0, 0);
        check("unhalt_halted", {63'd0, halted}, 64'd0);
        check("unhalt_valid", {63'd0, fetch_valid}, 64'd1);
        check("unhalt_pc", fetch_pc, 64'h3000);
        cyc(1, 0, 0, 0, 1, 64'h3000);
        check("unhalt_3004", fetch_pc, 64'h3004);

        // Asynchronous reset mid-stream, then redirect cases
        do_reset();
        cyc(1, 0, 0, 0, 1, 64'h1000);
        check("r2_1004", fetch_pc, 64'h1004);
        cyc(1, 0, 1, 64'h2000, 1, 64'h1004);
        check("redir_acc_pc", fetch_pc, 64'h2000);
        cyc(1, 0, 0, 0, 1, 64'h2000);
        check("redir_acc_next", fetch_pc, 64'h2004);
        cyc(1, 0, 1, 64'h1000, 1, 64'h2004);
        cyc(1, 0, 0, 0, 1, 64'h1000);
        check("r2b_1004", fetch_pc, 64'h1004);
        cyc(0, 0, 1, 64'h2000, 0, 0);
        check("redir_noacc_pc", fetch_pc, 64'h2000);
        check("redir_noacc_valid", {63'd0, fetch_valid}, 64'd1);
        cyc(1, 0, 0, 0, 1, 64'h2000);
        check("redir_noacc_next", fetch_pc, 64'h2004);

        // Wrap-around at the top of the address space
        cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
        check("wrap_setup", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pc", fetch_pc, 64'h0);
        check("wrap_err", {63'd0, misalign_err}, 64'd0);

        // Misaligned redirect
        cyc(0, 0, 1, 64'h2002, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
        check("misal_pc", fetch_pc, 64'h0);
        check("misal_err", {63'd0, misalign_err}, 64'd1);
        cyc(0, 0, 0, 0, 0, 0);
        check("misal_sticky", {63'd0, misalign_err}, 64'd1);
`else
        check("misal_pc", fetch_pc, 64'h2002);
        check("misal_err", {63'd0, misalign_err}, 64'd0);
        cyc(0, 0, 0, 0, 0, 0);
        check("misal_hold", fetch_pc, 64'h2002);
`endif
        do_reset();
        check("post_rst_err", {63'd0, misalign_err}, 64'd0);
        cyc(0, 0, 0, 0, 0, 0);

        total = total + 1;
        if (exp_q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
